// File: rtl/spi_bridge_pkg.sv
// Shared definitions for the AHB-Lite to SPI command bridge: FSM state
// encoding, command word field positions, AHB encodings and HADDR decode.
`timescale 1ns/1ps
package spi_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_DATA = 3'd1,
    RD_PUSH = 3'd2,
    RD_WAIT = 3'd3,
    ERR1    = 3'd4,
    ERR2    = 3'd5
  } bridge_state_e;

  // Command word: {wr_rd_en, chip_sel, addr[6:0], data[31:0]}
  localparam int CMD_W    = 41;
  localparam int WR_BIT   = 40;
  localparam int CS_BIT   = 39;
  localparam int ADDR_MSB = 38;
  localparam int ADDR_LSB = 32;
  localparam int ADDR_W   = ADDR_MSB - ADDR_LSB + 1;

  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  // HADDR decode
  localparam int HADDR_CS_BIT   = 9;
  localparam int HADDR_REG_MSB  = 8;
  localparam int HADDR_REG_LSB  = 2;

  // Slave is ready only when idle or finishing the second error cycle
  function automatic logic ready_of(input bridge_state_e s);
    return (s == IDLE) || (s == ERR2);
  endfunction

  // ERROR response spans both error cycles
  function automatic logic resp_of(input bridge_state_e s);
    return (s == ERR1) || (s == ERR2);
  endfunction

endpackage

// File: rtl/spi_bridge_rd_timer.sv
// Read-wait timer: counts cycles spent waiting for RX data and strobes
// expire_o on the TIMEOUT_CYCLES-th waiting cycle. Only instantiated when
// SPI_BRIDGE_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module spi_bridge_rd_timer
  import spi_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic run_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;

  assign expire_o = run_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count waiting cycles; restart from zero each time a wait begins
  always_ff @(posedge clk_i) begin
    if (reset_i || clr_i) begin
      cnt_q <= '0;
    end else if (run_i && !expire_o) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ahb_spi_cmd_bridge.sv
// AHB-Lite slave that converts word accesses into 41-bit SPI command words
// pushed into the TX FIFO, and returns read data popped from the RX FIFO.
// Optional feature macro: SPI_BRIDGE_TIMEOUT_EN (read timeout + late-word
// discard). Without it a read waits for RX data indefinitely.
`timescale 1ns/1ps
module ahb_spi_cmd_bridge
  import spi_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             HSEL,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             HWRITE,
  input  logic [2:0]       HSIZE,
  input  logic [31:0]      HWDATA,
  input  logic             HREADY,
  output logic             HREADYOUT,
  output logic             HRESP,
  output logic [31:0]      HRDATA,
  output logic [CMD_W-1:0] Tx_FIFO_data_out,
  output logic             Tx_FIFO_write_en,
  input  logic             Tx_FIFO_full,
  input  logic [31:0]      Rx_FIFO_data_in,
  output logic             Rx_FIFO_read_en,
  input  logic             Rx_FIFO_empty
);

  bridge_state_e     state_q, state_d;
  logic              cs_q;
  logic [ADDR_W-1:0] addr_q;
  logic              hreadyout_q;
  logic              hresp_q;
  logic [31:0]       hrdata_q;
  logic [CMD_W-1:0]  tx_data_q;
  logic              tx_we_q;
  logic              rx_re_q;

  logic              xfer_req;
  logic              xfer_bad;
  logic              rd_take;
  logic              disc_pop;
  logic              discard_q;
  logic              tmr_expire;

  logic              unused_haddr;
  assign unused_haddr = ^HADDR[31:HADDR_CS_BIT+1];

  // Active address phase: selected, NONSEQ/SEQ, and the bus is ready
  assign xfer_req = HSEL && HREADY &&
                    ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
  assign xfer_bad = (HSIZE != HSIZE_WORD) || (HADDR[1:0] != 2'b00);

  // A head word already being popped this cycle must not be consumed again,
  // so both the read completion and the discard pop skip that cycle.
  assign rd_take  = (state_q == RD_WAIT) && !Rx_FIFO_empty && !discard_q && !rx_re_q;
  assign disc_pop = discard_q && !Rx_FIFO_empty && !rx_re_q;

`ifdef SPI_BRIDGE_TIMEOUT_EN
  logic tmr_clr;
  logic tmr_run;

  assign tmr_clr = (state_q == RD_PUSH) && (state_d == RD_WAIT);
  assign tmr_run = (state_q == RD_WAIT);

  spi_bridge_rd_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rd_timer (
    .clk_i    (clk),
    .reset_i  (reset),
    .clr_i    (tmr_clr),
    .run_i    (tmr_run),
    .expire_o (tmr_expire)
  );

  // Remember that a timed-out read still owes one RX word to be dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      discard_q <= 1'b0;
    end else if ((state_q == RD_WAIT) && (state_d == ERR1)) begin
      discard_q <= 1'b1;
    end else if (disc_pop) begin
      discard_q <= 1'b0;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign tmr_expire     = 1'b0;
  assign discard_q      = 1'b0;
`endif

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (xfer_req) begin
          if (xfer_bad)    state_d = ERR1;
          else if (HWRITE) state_d = WR_DATA;
          else             state_d = RD_PUSH;
        end
      end
      WR_DATA: if (!Tx_FIFO_full) state_d = IDLE;
      RD_PUSH: if (!Tx_FIFO_full) state_d = RD_WAIT;
      RD_WAIT: begin
        if (rd_take)         state_d = IDLE;
        else if (tmr_expire) state_d = ERR1;
      end
      ERR1:    state_d = ERR2;
      ERR2:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus FSM with registered handshake, command push and read data capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= '0;
      tx_data_q   <= '0;
      tx_we_q     <= 1'b0;
      rx_re_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hreadyout_q <= ready_of(state_d);
      hresp_q     <= resp_of(state_d);
      tx_we_q     <= 1'b0;
      rx_re_q     <= disc_pop;
      case (state_q)
        IDLE: begin
          if (xfer_req) begin
            cs_q   <= HADDR[HADDR_CS_BIT];
            addr_q <= HADDR[HADDR_REG_MSB:HADDR_REG_LSB];
          end
        end
        WR_DATA: begin
          if (!Tx_FIFO_full) begin
            tx_data_q <= {1'b1, cs_q, addr_q, HWDATA};
            tx_we_q   <= 1'b1;
          end
        end
        RD_PUSH: begin
          if (!Tx_FIFO_full) begin
            tx_data_q <= {1'b0, cs_q, addr_q, 32'h0};
            tx_we_q   <= 1'b1;
          end
        end
        RD_WAIT: begin
          if (rd_take) begin
            hrdata_q <= Rx_FIFO_data_in;
            rx_re_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign HREADYOUT        = hreadyout_q;
  assign HRESP            = hresp_q;
  assign HRDATA           = hrdata_q;
  assign Tx_FIFO_data_out = tx_data_q;
  assign Tx_FIFO_write_en = tx_we_q;
  assign Rx_FIFO_read_en  = rx_re_q;

endmodule

// File: tb/tb_ahb_spi_cmd_bridge.sv
// Directed bench for ahb_spi_cmd_bridge. Expected command words go into a
// scoreboard queue when a transfer is issued and are compared when the DUT
// strobes Tx_FIFO_write_en; an RX FIFO model feeds read data.
`timescale 1ns/1ps
module tb_ahb_spi_cmd_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic [40:0] Tx_FIFO_data_out;
  logic        Tx_FIFO_write_en;
  logic        Tx_FIFO_full;
  logic [31:0] Rx_FIFO_data_in;
  logic        Rx_FIFO_read_en;
  logic        Rx_FIFO_empty;

  always #5 clk = ~clk;

  ahb_spi_cmd_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .HSEL             (HSEL),
    .HADDR            (HADDR),
    .HTRANS           (HTRANS),
    .HWRITE           (HWRITE),
    .HSIZE            (HSIZE),
    .HWDATA           (HWDATA),
    .HREADY           (HREADY),
    .HREADYOUT        (HREADYOUT),
    .HRESP            (HRESP),
    .HRDATA           (HRDATA),
    .Tx_FIFO_data_out (Tx_FIFO_data_out),
    .Tx_FIFO_write_en (Tx_FIFO_write_en),
    .Tx_FIFO_full     (Tx_FIFO_full),
    .Rx_FIFO_data_in  (Rx_FIFO_data_in),
    .Rx_FIFO_read_en  (Rx_FIFO_read_en),
    .Rx_FIFO_empty    (Rx_FIFO_empty)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          tx_cnt   = 0;
  int          pop_cnt  = 0;
  logic [40:0] txq[$];
  logic [31:0] rxq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rx_refresh();
    Rx_FIFO_empty = (rxq.size() == 0);
    if (rxq.size() != 0) Rx_FIFO_data_in = rxq[0];
    else                 Rx_FIFO_data_in = 32'h0;
  endtask

  task automatic rx_push(input logic [31:0] w);
    rxq.push_back(w);
    rx_refresh();
  endtask

  // Per-cycle observation of FIFO strobes (called once per cycle at negedge)
  task automatic mon();
    logic [40:0] exp_w;
    if (Tx_FIFO_write_en) begin
      tx_cnt++;
      chk("tx_push_expected", 64'(txq.size() != 0), 64'd1);
      if (txq.size() != 0) begin
        exp_w = txq.pop_front();
        chk("tx_word", 64'(Tx_FIFO_data_out), 64'(exp_w));
      end
    end
    if (Rx_FIFO_read_en) begin
      pop_cnt++;
      chk("rx_pop_nonempty", 64'(Rx_FIFO_empty), 64'd0);
      if (rxq.size() != 0) begin
        void'(rxq.pop_front());
        rx_refresh();
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    mon();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  // Issue one transfer from a sampled ready cycle; returns at the sampled
  // cycle in which HREADYOUT comes back high.
  task automatic ahb_xfer(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                          input logic [31:0] wd, input int full_cyc,
                          input int rx_at, input logic [31:0] rx_word,
                          output int waits, output logic resp_w, output logic resp_last,
                          output logic we_last, output logic re_last);
    int   cyc;
    logic done;
    if (sz == 3'b010 && a[1:0] == 2'b00)
      txq.push_back({wr, a[9], a[8:2], (wr ? wd : 32'h0)});
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HADDR = a; HSIZE = sz;
    advance();
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wd;
    Tx_FIFO_full = (full_cyc > 0);
    cyc = 1;
    if (rx_at == 1) rx_push(rx_word);
    waits = 0; resp_w = 1'b0; done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      sample();
      if (HREADYOUT) begin
        done = 1'b1;
      end else begin
        waits++;
        resp_w = HRESP;
        advance();
        cyc++;
        if (waits >= full_cyc) Tx_FIFO_full = 1'b0;
        if (cyc == rx_at) rx_push(rx_word);
      end
    end
    chk("xfer_completes", 64'(done), 64'd1);
    resp_last = HRESP;
    we_last   = Tx_FIFO_write_en;
    re_last   = Rx_FIFO_read_en;
  endtask

  int   waits;
  logic rw, rl, we, re;
  int   pops0, tx0;

  initial begin
    reset = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'b010; HWDATA = '0; HREADY = 1'b1; Tx_FIFO_full = 1'b0;
    rx_refresh();
    repeat (3) advance();
    sample();
    chk("rst_hreadyout", 64'(HREADYOUT), 64'd1);
    chk("rst_hresp", 64'(HRESP), 64'd0);
    chk("rst_hrdata", 64'(HRDATA), 64'd0);
    chk("rst_tx_data", 64'(Tx_FIFO_data_out), 64'd0);
    chk("rst_tx_we", 64'(Tx_FIFO_write_en), 64'd0);
    chk("rst_rx_re", 64'(Rx_FIFO_read_en), 64'd0);
    reset = 1'b0;

    // Inactive transfers: BUSY, then NONSEQ with HREADY low
    HSEL = 1'b1; HTRANS = 2'b01; HWRITE = 1'b1; HADDR = 32'h208;
    advance(); sample();
    chk("busy_ready", 64'(HREADYOUT), 64'd1);
    HTRANS = 2'b10; HREADY = 1'b0;
    advance(); sample();
    chk("hready_low_ignored", 64'(HREADYOUT), 64'd1);
    HSEL = 1'b0; HTRANS = 2'b00; HREADY = 1'b1;
    advance(); sample();
    chk("inactive_no_push", 64'(tx_cnt), 64'd0);

    // Write, TX not full: one wait state
    ahb_xfer(1'b1, 32'h0000_0208, 3'b010, 32'hDEADBEEF, 0, 0, 32'h0, waits, rw, rl, we, re);
    chk("wr_waits", 64'(waits), 64'd1);
    chk("wr_resp", 64'({rw, rl}), 64'd0);
    chk("wr_we_at_ready", 64'(we), 64'd1);
    chk("wr_push_cnt", 64'(tx_cnt), 64'd1);

    // Back-to-back read; RX becomes non-empty 40 cycles after the push
    ahb_xfer(1'b0, 32'h0000_0010, 3'b010, 32'h0, 0, 42, 32'h12345678, waits, rw, rl, we, re);
    chk("rd_waits", 64'(waits), 64'd42);
    chk("rd_resp", 64'({rw, rl}), 64'd0);
    chk("rd_re_at_ready", 64'(re), 64'd1);
    chk("rd_data", 64'(HRDATA), 64'h12345678);
    chk("rd_pop_cnt", 64'(pop_cnt), 64'd1);

    // Write with TX full for 5 data-phase cycles
    ahb_xfer(1'b1, 32'h0000_03FC, 3'b010, 32'hA5A55A5A, 5, 0, 32'h0, waits, rw, rl, we, re);
    chk("wr_full_waits", 64'(waits), 64'd6);
    chk("wr_full_we", 64'(we), 64'd1);
    chk("wr_full_push_cnt", 64'(tx_cnt), 64'd3);

    // Illegal size write and misaligned read: two-cycle ERROR, no FIFO traffic
    tx0 = tx_cnt; pops0 = pop_cnt;
    ahb_xfer(1'b1, 32'h0000_0208, 3'b000, 32'h11111111, 0, 0, 32'h0, waits, rw, rl, we, re);
    chk("err_size_waits", 64'(waits), 64'd1);
    chk("err_size_resp", 64'({rw, rl}), 64'd3);
    advance(); sample();
    ahb_xfer(1'b0, 32'h0000_0012, 3'b010, 32'h0, 0, 0, 32'h0, waits, rw, rl, we, re);
    chk("err_align_waits", 64'(waits), 64'd1);
    chk("err_align_resp", 64'({rw, rl}), 64'd3);
    advance(); sample();
    chk("err_no_push", 64'(tx_cnt), 64'(tx0));
    chk("err_no_pop", 64'(pop_cnt), 64'(pops0));

`ifdef SPI_BRIDGE_TIMEOUT_EN
    // Read timeout after 16 RD_WAIT cycles; late word dropped
    ahb_xfer(1'b0, 32'h0000_0040, 3'b010, 32'h0, 0, 1000, 32'h0, waits, rw, rl, we, re);
    chk("to_waits", 64'(waits), 64'd18);
    chk("to_resp", 64'({rw, rl}), 64'd3);
    pops0 = pop_cnt;
    repeat (11) begin advance(); sample(); end
    advance();
    rx_push(32'hBAD0BAD0);
    sample();
    repeat (4) begin advance(); sample(); end
    chk("to_discard_pop", 64'(pop_cnt), 64'(pops0 + 1));
    chk("to_rx_drained", 64'(rxq.size()), 64'd0);
    chk("to_hrdata_kept", 64'(HRDATA), 64'h12345678);
    rx_push(32'hCAFEF00D);
    ahb_xfer(1'b0, 32'h0000_0044, 3'b010, 32'h0, 0, 0, 32'h0, waits, rw, rl, we, re);
    chk("to_next_waits", 64'(waits), 64'd2);
    chk("to_next_data", 64'(HRDATA), 64'hCAFEF00D);
`endif

    // Reset in RD_WAIT: reset values next cycle, no pop afterwards
    txq.push_back({1'b0, 1'b0, 7'h08, 32'h0});
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h0000_0020; HSIZE = 3'b010;
    advance();
    HSEL = 1'b0; HTRANS = 2'b00;
    repeat (4) begin sample(); advance(); end
    reset = 1'b1;
    sample(); advance();
    reset = 1'b0;
    sample();
    chk("mid_rst_hreadyout", 64'(HREADYOUT), 64'd1);
    chk("mid_rst_hresp", 64'(HRESP), 64'd0);
    chk("mid_rst_hrdata", 64'(HRDATA), 64'd0);
    chk("mid_rst_strobes", 64'({Tx_FIFO_write_en, Rx_FIFO_read_en}), 64'd0);
    pops0 = pop_cnt;
    rx_push(32'h600DF00D);
    repeat (3) begin advance(); sample(); end
    chk("mid_rst_no_pop", 64'(pop_cnt), 64'(pops0));
    chk("mid_rst_rx_kept", 64'(rxq.size()), 64'd1);
    ahb_xfer(1'b0, 32'h0000_0024, 3'b010, 32'h0, 0, 0, 32'h0, waits, rw, rl, we, re);
    chk("post_rst_waits", 64'(waits), 64'd2);
    chk("post_rst_data", 64'(HRDATA), 64'h600DF00D);

    advance(); sample();
    chk("tx_scoreboard_empty", 64'(txq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
